// File: rtl/rx_fifo36_to_gpif16.sv
// rx_fifo36_to_gpif16: 36-bit RX packet stream to 16-bit GPIF bulk buffers.
// Each 32-bit payload word is split into halfwords. Any buffer left partly
// filled at packet end is padded up to the next BUF_WORDS boundary.
//
// Ports:
//   clk, reset_n (async, active-low), clear (sync flush)
//   in_data[35:0]  : [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy
//   in_src_rdy/in_dst_rdy   : input valid/ready handshake
//   out_data[15:0], out_eob : host halfword, last word of a buffer
//   out_src_rdy/out_dst_rdy : output valid/ready handshake
//   pad_count, pkt_count    : saturating statistics counters, present only
//                             when RX_GPIF_PAD_STATS_EN is defined
module rx_fifo36_to_gpif16 #(
    parameter int          BUF_WORDS = 256,
    parameter logic [15:0] PAD_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [35:0] in_data,
    input  logic        in_src_rdy,
    output logic        in_dst_rdy,
    output logic [15:0] out_data,
    output logic        out_eob,
    output logic        out_src_rdy,
    input  logic        out_dst_rdy
`ifdef RX_GPIF_PAD_STATS_EN
    ,
    output logic [31:0] pad_count,
    output logic [31:0] pkt_count
`endif
);

    localparam int            CW       = $clog2(BUF_WORDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUF_WORDS - 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_HIGH,
        ST_PAD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [35:0]   hold;
    logic          hold_full;
    logic [CW-1:0] word_cnt;

    logic          hold_eof;
    logic          hold_short;
    logic          at_last;
    logic          last_half;
    logic          out_xfer;
    logic          in_xfer;

    // SOF travels through the hold register but is never acted upon.
    logic          hold_sof_unused;
    assign hold_sof_unused = hold[32];

    assign hold_eof   = hold[33];
    // An EOF word with 1 or 2 valid bytes only fills the low halfword.
    assign hold_short = hold_eof &
                        ((hold[35:34] == 2'd1) | (hold[35:34] == 2'd2));
    assign at_last    = (word_cnt == CNT_LAST);

    // The pad check is folded into the transfer cycle: an EOF landing on
    // the final word of a buffer goes straight back to LOW.
    always_comb begin
        state_nxt   = state;
        out_src_rdy = 1'b0;
        out_data    = '0;
        last_half   = 1'b0;
        unique case (state)
            ST_LOW: begin
                out_src_rdy = hold_full;
                if (hold_full) begin
                    out_data = hold[15:0];
                end
                if (hold_full && out_dst_rdy) begin
                    if (hold_short) begin
                        last_half = 1'b1;
                        state_nxt = at_last ? ST_LOW : ST_PAD;
                    end else begin
                        state_nxt = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                out_src_rdy = 1'b1;
                out_data    = hold[31:16];
                if (out_dst_rdy) begin
                    last_half = 1'b1;
                    if (hold_eof) begin
                        state_nxt = at_last ? ST_LOW : ST_PAD;
                    end else begin
                        state_nxt = ST_LOW;
                    end
                end
            end
            ST_PAD: begin
                out_src_rdy = 1'b1;
                out_data    = PAD_WORD;
                if (out_dst_rdy && at_last) begin
                    state_nxt = ST_LOW;
                end
            end
            default: begin
                state_nxt = ST_LOW;
            end
        endcase
    end

    assign out_xfer = out_src_rdy & out_dst_rdy;
    assign out_eob  = out_src_rdy & at_last;

    // Refill the hold register in the same cycle its final half leaves,
    // which sustains one input word every two cycles.
    assign in_dst_rdy = (state != ST_PAD) & (~hold_full | last_half);
    assign in_xfer    = in_src_rdy & in_dst_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_LOW;
            hold      <= '0;
            hold_full <= 1'b0;
            word_cnt  <= '0;
        end else if (clear) begin
            state     <= ST_LOW;
            hold      <= '0;
            hold_full <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (out_xfer) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (in_xfer) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end else if (last_half) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef RX_GPIF_PAD_STATS_EN
    logic pad_xfer;
    logic eof_done;

    assign pad_xfer = out_xfer & (state == ST_PAD);
    assign eof_done = last_half & hold_eof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_count <= '0;
            pkt_count <= '0;
        end else if (clear) begin
            pad_count <= '0;
            pkt_count <= '0;
        end else begin
            if (pad_xfer && (pad_count != '1)) begin
                pad_count <= pad_count + 32'd1;
            end
            if (eof_done && (pkt_count != '1)) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_fifo36_to_gpif16.sv
// Testbench for rx_fifo36_to_gpif16 with BUF_WORDS=8.
// Scoreboard of expected halfwords built from a packet-level model.
module tb_rx_fifo36_to_gpif16;

    localparam int          BW = 8;
    localparam logic [15:0] PW = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [35:0] in_data = '0;
    logic        in_src_rdy = 1'b0;
    logic        in_dst_rdy;
    logic [15:0] out_data;
    logic        out_eob;
    logic        out_src_rdy;
    logic        out_dst_rdy = 1'b1;
`ifdef RX_GPIF_PAD_STATS_EN
    logic [31:0] pad_count;
    logic [31:0] pkt_count;
`endif

    rx_fifo36_to_gpif16 #(
        .BUF_WORDS(BW),
        .PAD_WORD (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_src_rdy (in_src_rdy),
        .in_dst_rdy (in_dst_rdy),
        .out_data   (out_data),
        .out_eob    (out_eob),
        .out_src_rdy(out_src_rdy),
        .out_dst_rdy(out_dst_rdy)
`ifdef RX_GPIF_PAD_STATS_EN
        ,
        .pad_count  (pad_count),
        .pkt_count  (pkt_count)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];
    int          pos = 0;
    int          out_cnt = 0;
    int          rdy_mode = 0;
    int          m_pad = 0;
    int          m_pkt = 0;

    always #5 clk = ~clk;

    // Host ready: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_dst_rdy = 1'b1;
            1:       out_dst_rdy = 1'($urandom_range(0, 1));
            default: out_dst_rdy = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [35:0] act,
                         input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] mk(input logic [31:0] d,
                                       input logic sof, input logic eof,
                                       input logic [1:0] occ);
        return {occ, eof, sof, d};
    endfunction

    // Reference model: halfword stream with buffer position bookkeeping.
    task automatic push_half(input logic [15:0] d);
        logic e;
        e = ((pos % BW) == BW - 1);
        exp_q.push_back({e, d});
        pos++;
    endtask

    task automatic model_word(input logic [35:0] w);
        logic short_eof;
        short_eof = w[33] && (w[35:34] == 2'd1 || w[35:34] == 2'd2);
        push_half(w[15:0]);
        if (!short_eof) push_half(w[31:16]);
        if (w[33]) begin
            m_pkt++;
            while ((pos % BW) != 0) begin
                push_half(PW);
                m_pad++;
            end
        end
    endtask

    // Monitor: compares every output transfer and stall stability.
    logic        stall_prev = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_e = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset_n || clear) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_src_rdy", 36'(out_src_rdy), 36'd1);
                check("stall_data", 36'(out_data), 36'(prev_d));
                check("stall_eob", 36'(out_eob), 36'(prev_e));
            end
            if (!out_src_rdy) check("idle_eob", 36'(out_eob), 36'd0);
            if (out_src_rdy && out_dst_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %h eob %b expected none",
                             out_data, out_eob);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 36'(out_data), 36'(e[15:0]));
                    check("out_eob", 36'(out_eob), 36'(e[16]));
                end
                out_cnt++;
            end
            stall_prev = out_src_rdy && !out_dst_rdy;
            prev_d = out_data;
            prev_e = out_eob;
        end
    end

    task automatic send(input logic [35:0] w);
        int n;
        bit ok;
        in_data = w;
        in_src_rdy = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_dst_rdy) ok = 1'b1;
            n++;
        end
        check("send_accept", 36'(ok), 36'd1);
        if (ok) model_word(w);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            logic [1:0] occ;
            occ = (i == len - 1) ? 2'($urandom_range(0, 3)) : 2'd0;
            send(mk($urandom, i == 0, i == len - 1, occ));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_src_rdy) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 36'(n < 5000), 36'd1);
        repeat (3) @(negedge clk);
        check("idle_src_rdy", 36'(out_src_rdy), 36'd0);
        check("idle_in_dst_rdy", 36'(in_dst_rdy), 36'd1);
        check("idle_out_data", 36'(out_data), 36'd0);
`ifdef RX_GPIF_PAD_STATS_EN
        check("pad_count", 36'(pad_count), 36'(m_pad));
        check("pkt_count", 36'(pkt_count), 36'(m_pkt));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target);
        int n;
        n = 0;
        while (out_cnt < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("wait_out", 36'(out_cnt >= target), 36'd1);
    endtask

    task automatic flush_model();
        exp_q.delete();
        pos = 0;
        m_pad = 0;
        m_pkt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_src_rdy"}, 36'(out_src_rdy), 36'd0);
        check({tag, "_eob"}, 36'(out_eob), 36'd0);
        check({tag, "_data"}, 36'(out_data), 36'd0);
        check({tag, "_in_dst_rdy"}, 36'(in_dst_rdy), 36'd1);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-word packet: 4 data halfwords then 4 pads.
        send(mk(32'h44332211, 1'b1, 1'b0, 2'd0));
        send(mk(32'h88776655, 1'b0, 1'b1, 2'd0));
        in_src_rdy = 1'b0;
        wait_drain();

        // Short EOF: only BBBB emitted, then 7 pads.
        send(mk(32'hAAAABBBB, 1'b1, 1'b1, 2'd2));
        in_src_rdy = 1'b0;
        wait_drain();

        // Exactly one buffer, no padding.
        for (int i = 0; i < 4; i++)
            send(mk(32'h10000000 + i, i == 0, i == 3, 2'd0));
        in_src_rdy = 1'b0;
        wait_drain();

        // Spans two buffers; second one padded.
        for (int i = 0; i < 5; i++)
            send(mk(32'h20000000 + i, i == 0, i == 4, 2'd3));
        in_src_rdy = 1'b0;
        wait_drain();

        // Random traffic with random host stalls.
        rdy_mode = 1;
        for (int p = 0; p < 100; p++)
            send_rand_pkt($urandom_range(1, 12));
        in_src_rdy = 1'b0;
        wait_drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Async reset in PAD with word_cnt=3.
        base = out_cnt;
        send(mk(32'hCAFEF00D, 1'b1, 1'b1, 2'd0));
        in_src_rdy = 1'b0;
        wait_out(base + 3);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        flush_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            send(mk(32'h30000000 + i, i == 0, i == 3, 2'd0));
        in_src_rdy = 1'b0;
        wait_drain();

        // Clear mid-PAD with a simultaneous input offer that must be dropped.
        base = out_cnt;
        send(mk(32'h0BADBEEF, 1'b1, 1'b1, 2'd1));
        in_src_rdy = 1'b0;
        wait_out(base + 2);
        #1;
        clear = 1'b1;
        in_data = mk(32'h55555555, 1'b1, 1'b1, 2'd0);
        in_src_rdy = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_src_rdy = 1'b0;
        #1;
        check_reset_vals("clear");
        for (int i = 0; i < 3; i++)
            send(mk(32'h40000000 + i, i == 0, i == 2, 2'd0));
        in_src_rdy = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
